// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX path, the RX buffer and the TX buffer.
//   DATA_W      : width of one UART character
//   uart_byte_t : one UART character
package uart_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_core.sv
// Synchronous FIFO storage with a plain write/read-enable interface.
// The head entry is presented combinationally on rd_data (fall-through read).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   wr_en, wr_data  : write request and data; accepted when not full or when
//                     a read is accepted in the same cycle
//   rd_en           : read request; ignored while empty
//   rd_data         : mem[rd_ptr], meaningful only when not empty
//   count           : occupancy 0..DEPTH
//   full, empty     : derived from count
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter  int DATA_W = uart_pkg::DATA_W,
    parameter  int DEPTH  = 16,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A read in the same cycle frees a slot, so a write while full is still taken.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; empty gating downstream hides stale contents.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind uart_rx. Captures shift_reg on each rising
// edge of rx_ready and presents bytes through a first-word-fall-through
// valid/ready interface.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   rx_data       : byte from uart_rx shift_reg
//   rx_ready      : frame-complete level from uart_rx (may stay high)
//   m_data        : head byte, forced to 0 while empty
//   m_valid       : FIFO non-empty
//   m_ready       : host accepts the head byte this cycle
//   count         : occupancy 0..DEPTH
//   full, empty   : occupancy flags
//   overflow      : sticky, a byte was dropped because the FIFO was full
//   clr_overflow  : clears overflow (a simultaneous drop keeps it set)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = uart_pkg::DATA_W,
    parameter  int DEPTH  = 16,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_overflow
);

    logic              rx_ready_q;
    logic              wr_evt;
    logic              rd_evt;
    logic              drop;
    logic [DATA_W-1:0] head;

    // rx_ready_q resets high so a level already present at release is not a new frame.
    assign wr_evt  = rx_ready & ~rx_ready_q;
    assign m_valid = ~empty;
    assign rd_evt  = m_valid & m_ready;
    assign drop    = wr_evt & full & ~rd_evt;
    assign m_data  = empty ? '0 : head;

    uart_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_evt),
        .wr_data (rx_data),
        .rd_en   (rd_evt),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ready_q <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready;
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a vector table for the basic capture
// and handshake behaviour, hand sequences for full/overflow/reset corners, and
// a randomized run against a queue-based reference model.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             clr_overflow;

    uart_rx_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: byte queue, sticky flag, previous rx_ready level.
    logic [7:0] mq[$];
    logic       m_ovf;
    logic       m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_prev = 1'b1;
    endtask

    // Applies the rules for one clock edge using the inputs currently driven.
    task automatic model_step();
        logic new_frame;
        logic dropped;
        new_frame = rx_ready && !m_prev;
        dropped   = 1'b0;
        if (m_ready && mq.size() != 0) void'(mq.pop_front());
        if (new_frame) begin
            if (mq.size() < DEPTH) mq.push_back(rx_data);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr_overflow) m_ovf = 1'b0;
        m_prev = rx_ready;
    endtask

    // Drive inputs at the falling edge, step the model, advance one full cycle.
    task automatic cyc(input logic rdy, input logic [7:0] d, input logic mr, input logic clr);
        rx_ready     = rdy;
        rx_data      = d;
        m_ready      = mr;
        clr_overflow = clr;
        model_step();
        @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0);
        cyc(1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"},    32'(count),    32'(n));
        chk({tag, ".m_valid"},  32'(m_valid),  32'(n != 0));
        chk({tag, ".empty"},    32'(empty),    32'(n == 0));
        chk({tag, ".full"},     32'(full),     32'(n == DEPTH));
        chk({tag, ".m_data"},   32'(m_data),   (n != 0) ? 32'(mq[0]) : 32'h0);
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    typedef struct {
        logic       rdy;
        logic [7:0] d;
        logic       mr;
        logic [4:0] cnt;
        logic       vld;
        logic [7:0] hd;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00}; // level held across release
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b1, 8'hA5}; // rising edge captures
        tbl[3]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b1, 8'hA5};
        tbl[4]  = '{1'b0, 8'hA5, 1'b0, 5'd1, 1'b1, 8'hA5};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 8'h00, 1'b0, 5'd1, 1'b1, 8'h00}; // held high 5 cycles
        tbl[7]  = '{1'b1, 8'h00, 1'b0, 5'd1, 1'b1, 8'h00};
        tbl[8]  = '{1'b1, 8'h00, 1'b0, 5'd1, 1'b1, 8'h00};
        tbl[9]  = '{1'b1, 8'h00, 1'b0, 5'd1, 1'b1, 8'h00};
        tbl[10] = '{1'b1, 8'h00, 1'b0, 5'd1, 1'b1, 8'h00};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 8'h00};
        tbl[12] = '{1'b1, 8'hFF, 1'b0, 5'd2, 1'b1, 8'h00};
        tbl[13] = '{1'b0, 8'hFF, 1'b1, 5'd1, 1'b1, 8'hFF};
        tbl[14] = '{1'b0, 8'hFF, 1'b1, 5'd0, 1'b0, 8'h00};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00}; // read while empty ignored
        tbl[16] = '{1'b1, 8'h77, 1'b1, 5'd1, 1'b1, 8'h77}; // write+read while empty
        tbl[17] = '{1'b0, 8'h77, 1'b1, 5'd0, 1'b0, 8'h00};

        rst          = 1'b1;
        rx_ready     = 1'b1;
        rx_data      = 8'h00;
        m_ready      = 1'b0;
        clr_overflow = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset.count",    32'(count),    32'h0);
        chk("reset.empty",    32'(empty),    32'h1);
        chk("reset.full",     32'(full),     32'h0);
        chk("reset.m_valid",  32'(m_valid),  32'h0);
        chk("reset.m_data",   32'(m_data),   32'h0);
        chk("reset.overflow", 32'(overflow), 32'h0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].rdy, tbl[i].d, tbl[i].mr, 1'b0);
            chk($sformatf("vec%0d.count", i),   32'(count),   32'(tbl[i].cnt));
            chk($sformatf("vec%0d.m_valid", i), 32'(m_valid), 32'(tbl[i].vld));
            chk($sformatf("vec%0d.m_data", i),  32'(m_data),  32'(tbl[i].hd));
            chk($sformatf("vec%0d.empty", i),   32'(empty),   32'(tbl[i].cnt == 5'd0));
        end

        // Fill to 16 then drop a 17th byte
        for (int i = 0; i < 16; i++) frame(8'(8'h10 + i));
        frame(8'h20);
        chk("ovf.full",     32'(full),     32'h1);
        chk("ovf.count",    32'(count),    32'd16);
        chk("ovf.overflow", 32'(overflow), 32'h1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf.pop%0d", i), 32'(m_data), 32'(8'h10 + i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("ovf.drained", 32'(empty), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf.cleared", 32'(overflow), 32'h0);

        // Write while full with a simultaneous read
        for (int i = 0; i < 16; i++) frame(8'(8'h40 + i));
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("fullrw.count",    32'(count),    32'd16);
        chk("fullrw.overflow", 32'(overflow), 32'h0);
        cyc(1'b0, 8'h55, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("fullrw.pop%0d", i), 32'(m_data), 32'(8'h40 + i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("fullrw.last", 32'(m_data), 32'h55);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullrw.empty", 32'(empty), 32'h1);

        // Drop and clear in the same cycle: set wins
        for (int i = 0; i < 16; i++) frame(8'(i));
        frame(8'h99);
        chk("clr.set", 32'(overflow), 32'h1);
        cyc(1'b1, 8'h9A, 1'b0, 1'b1);
        chk("clr.setwins", 32'(overflow), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr.alone", 32'(overflow), 32'h0);
        check_model("clr");
        for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_model("clr.drain");

        // Asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) frame(8'(8'hC0 + i));
        chk("arst.pre", 32'(count), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk("arst.count",    32'(count),    32'h0);
        chk("arst.empty",    32'(empty),    32'h1);
        chk("arst.m_valid",  32'(m_valid),  32'h0);
        chk("arst.overflow", 32'(overflow), 32'h0);
        chk("arst.m_data",   32'(m_data),   32'h0);
        model_reset();
        rx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        frame(8'h3C);
        chk("arst.first", 32'(m_data), 32'h3C);
        chk("arst.cnt1",  32'(count),  32'd1);
        check_model("arst");

        // Randomized run against the model; alternating slow/fast drain phases
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic mr;
            logic c;
            r  = 1'($urandom_range(0, 1));
            mr = ((i / 500) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 15) == 0);
            cyc(r, 8'($urandom), mr, c);
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
